// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, payload type and scoreboard arithmetic for the operand-fetch stage.
// The OPERAND_BYPASS_EN macro (see operand_fetch_stage.sv) enables writeback-to-operand bypass.
package operand_fetch_stage_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] addr_d;
    logic              we;
  } fetch_payload_t;

  function automatic logic is_tracked(input logic [ADDR_W-1:0] r);
    return r != REG_ZERO;
  endfunction

  // Net counter update: +inc, -dec_a, -dec_b, clamped to [0, CNT_MAX].
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic dec_a,
                                                input logic dec_b);
    logic [CNT_W:0] up;
    logic [CNT_W:0] down;
    up   = {1'b0, cur} + (CNT_W+1)'(inc);
    down = (CNT_W+1)'(dec_a) + (CNT_W+1)'(dec_b);
    if (down >= up)
      return '0;
    else if ((up - down) > {1'b0, CNT_MAX})
      return CNT_MAX;
    else
      return CNT_W'(up - down);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Per-register in-flight write counters with one increment and two decrement ports.
module operand_fetch_stage_reg_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] inc_addr_i,
  input  logic              dec_a_i,
  input  logic [ADDR_W-1:0] dec_a_addr_i,
  input  logic              dec_b_i,
  input  logic [ADDR_W-1:0] dec_b_addr_i,
  input  logic [ADDR_W-1:0] q_addr_a_i,
  input  logic [ADDR_W-1:0] q_addr_b_i,
  input  logic [ADDR_W-1:0] q_addr_d_i,
  output logic [CNT_W-1:0]  cnt_a_c,
  output logic [CNT_W-1:0]  cnt_b_c,
  output logic [CNT_W-1:0]  cnt_d_c
);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  // r0 is never tracked, so its counter is pinned at zero.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = '0;
      if (i != 0) begin
        cnt_d[i] = next_cnt(cnt_q[i],
                            inc_i   && (inc_addr_i   == ADDR_W'(i)),
                            dec_a_i && (dec_a_addr_i == ADDR_W'(i)),
                            dec_b_i && (dec_b_addr_i == ADDR_W'(i)));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_a_c = cnt_q[q_addr_a_i];
  assign cnt_b_c = cnt_q[q_addr_b_i];
  assign cnt_d_c = cnt_q[q_addr_d_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// One-entry operand-fetch stage with RAW scoreboard stalling and flush.
// Define OPERAND_BYPASS_EN to forward same-cycle writeback data into the operands.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr_a,
  input  logic [ADDR_W-1:0] in_addr_b,
  input  logic [ADDR_W-1:0] in_addr_d,
  input  logic              in_we,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_addr_d,
  output logic              out_we
);

  logic           out_valid_q, out_valid_d;
  fetch_payload_t pay_q, pay_d;

  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_dst;
  logic             byp_a, byp_b;
  logic             haz_a, haz_b, sat_d, hazard_free;
  logic             capture, sb_inc, sb_dec_wb, sb_dec_flush;
  logic [DATA_W-1:0] op_a, op_b;

  assign rf_addr_a = in_addr_a;
  assign rf_addr_b = in_addr_b;

`ifdef OPERAND_BYPASS_EN
  // A single outstanding write retiring this cycle is satisfied by the writeback bus.
  assign byp_a = wb_write && (wb_addr == in_addr_a);
  assign byp_b = wb_write && (wb_addr == in_addr_b);
  assign haz_a = is_tracked(in_addr_a) && (cnt_a != '0) && !((cnt_a == CNT_W'(1)) && byp_a);
  assign haz_b = is_tracked(in_addr_b) && (cnt_b != '0) && !((cnt_b == CNT_W'(1)) && byp_b);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
  assign haz_a = is_tracked(in_addr_a) && (cnt_a != '0);
  assign haz_b = is_tracked(in_addr_b) && (cnt_b != '0);
`endif

  assign sat_d       = in_we && is_tracked(in_addr_d) && (cnt_dst == CNT_MAX);
  assign hazard_free = !haz_a && !haz_b && !sat_d;
  assign in_ready    = hazard_free && (!out_valid_q || out_ready) && !flush;
  assign capture     = in_valid && in_ready;

  assign op_a = !is_tracked(in_addr_a) ? '0 : (byp_a ? wb_data : rf_a);
  assign op_b = !is_tracked(in_addr_b) ? '0 : (byp_b ? wb_data : rf_b);

  assign sb_inc       = capture && in_we && is_tracked(in_addr_d);
  assign sb_dec_wb    = wb_write && is_tracked(wb_addr);
  assign sb_dec_flush = flush && out_valid_q && pay_q.we && is_tracked(pay_q.addr_d);

  operand_fetch_stage_reg_scoreboard u_sb (
    .clk          (clk),
    .reset        (reset),
    .inc_i        (sb_inc),
    .inc_addr_i   (in_addr_d),
    .dec_a_i      (sb_dec_wb),
    .dec_a_addr_i (wb_addr),
    .dec_b_i      (sb_dec_flush),
    .dec_b_addr_i (pay_q.addr_d),
    .q_addr_a_i   (in_addr_a),
    .q_addr_b_i   (in_addr_b),
    .q_addr_d_i   (in_addr_d),
    .cnt_a_c      (cnt_a),
    .cnt_b_c      (cnt_b),
    .cnt_d_c      (cnt_dst)
  );

  // Flush wins; otherwise capture refills, or a consumed entry empties.
  always_comb begin
    out_valid_d = out_valid_q;
    pay_d       = pay_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d  = 1'b1;
      pay_d.op_a   = op_a;
      pay_d.op_b   = op_b;
      pay_d.imm    = in_imm;
      pay_d.addr_d = in_addr_d;
      pay_d.we     = in_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      pay_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pay_q       <= pay_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op_a   = pay_q.op_a;
  assign out_op_b   = pay_q.op_b;
  assign out_imm    = pay_q.imm;
  assign out_addr_d = pay_q.addr_d;
  assign out_we     = pay_q.we;

endmodule
